// File: rtl/digest_hex_serializer.sv
// digest_hex_serializer
// Captures a hash digest on the rising edge of hash_ready and streams it as
// lowercase/uppercase ASCII hex over a valid/ready byte interface, most
// significant nibble first, with an optional trailing line feed.
// All outputs come straight from flops so the sink sees no combinational path
// from char_ready back to char_valid.

module digest_hex_serializer #(
   parameter int DIGEST_W     = 64,
   parameter int UPPERCASE    = 0,
   parameter int EMIT_NEWLINE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                hash_ready,
   input  logic [DIGEST_W-1:0] digest_in,
   output logic [7:0]          char_out,
   output logic                char_valid,
   input  logic                char_ready,
   output logic                busy,
   output logic                done,
   output logic                overrun
);

   localparam int NCHARS = DIGEST_W / 4;
   localparam int IDX_W  = (NCHARS > 1) ? $clog2(NCHARS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHARS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [7:0]       CHAR_LF  = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_EOL  = 2'd2
   } state_e;

   // Map one nibble to its printable hex character.
   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      logic [7:0] c;
      if (nib < 4'd10) begin
         c = 8'h30 + {4'h0, nib};
      end else if (UPPERCASE != 0) begin
         c = 8'h37 + {4'h0, nib};   // 0x41 + (nib - 10)
      end else begin
         c = 8'h57 + {4'h0, nib};   // 0x61 + (nib - 10)
      end
      return c;
   endfunction

   // Select nibble number pos (0 = least significant) of a digest word.
   function automatic logic [3:0] nibble_at(input logic [DIGEST_W-1:0] vec,
                                            input logic [IDX_W-1:0]    pos);
      logic [3:0] nib;
      nib = 4'h0;
      for (int i = 0; i < NCHARS; i++) begin
         if (pos == IDX_W'(i)) begin
            nib = vec[4*i +: 4];
         end else begin
            nib = nib;
         end
      end
      return nib;
   endfunction

   state_e              state_q,   state_d;
   logic [IDX_W-1:0]    index_q,   index_d;
   logic [DIGEST_W-1:0] shadow_q,  shadow_d;
   logic                hr_q,      hr_d;
   logic [7:0]          char_q,    char_d;
   logic                valid_q,   valid_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;
   logic                overrun_q, overrun_d;

   logic start_s;
   logic xfer_s;
   logic last_s;

   assign start_s = hash_ready & ~hr_q;
   assign xfer_s  = valid_q & char_ready;
   assign last_s  = (index_q == LAST_IDX);

   // State and datapath registers; reset wins over every other event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         index_q   <= '0;
         shadow_q  <= '0;
         hr_q      <= 1'b1;   // a level already high at release is not an edge
         char_q    <= 8'h00;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         shadow_q  <= shadow_d;
         hr_q      <= hr_d;
         char_q    <= char_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   // Next-state selection: IDLE -> SEND on an edge, SEND walks the nibbles,
   // EOL holds the line feed until it is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (xfer_s && last_s) begin
               if (EMIT_NEWLINE != 0) begin
                  state_d = ST_EOL;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_EOL: begin
            if (xfer_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_EOL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values: the character for the next cycle is
   // prepared here so that char_out/char_valid leave the block from flops.
   always_comb begin
      shadow_d  = shadow_q;
      index_d   = index_q;
      char_d    = char_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hr_d      = hash_ready;

      // An edge arriving while a stream is in flight is dropped but remembered.
      if (start_s && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               shadow_d = digest_in;
               index_d  = '0;
               char_d   = hex_char(nibble_at(digest_in, LAST_IDX));
               valid_d  = 1'b1;
               busy_d   = 1'b1;
            end else begin
               valid_d  = 1'b0;
               busy_d   = 1'b0;
            end
         end
         ST_SEND: begin
            if (xfer_s) begin
               if (last_s) begin
                  if (EMIT_NEWLINE != 0) begin
                     char_d  = CHAR_LF;
                  end else begin
                     valid_d = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else begin
                  index_d = index_q + IDX_ONE;
                  char_d  = hex_char(nibble_at(shadow_q, LAST_IDX - index_q - IDX_ONE));
               end
            end else begin
               char_d = char_q;   // hold while the sink stalls
            end
         end
         ST_EOL: begin
            if (xfer_s) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               char_d  = CHAR_LF;
            end
         end
         default: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign char_out   = char_q;
   assign char_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_digest_hex_serializer.sv
// Bench for digest_hex_serializer: two instances (lowercase with line feed,
// uppercase without) share stimulus; a string-level model tracks the text each
// one still owes and is compared against the outputs every cycle.

module tb_digest_hex_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        hash_ready;
   logic        char_ready;
   logic [63:0] digest_in;

   logic [7:0] co_a, co_b;
   logic       cv_a, cv_b, bz_a, bz_b, dn_a, dn_b, ov_a, ov_b;

   digest_hex_serializer #(.DIGEST_W(64), .UPPERCASE(0), .EMIT_NEWLINE(1)) dut_a (
      .clk(clk), .rst(rst), .hash_ready(hash_ready), .digest_in(digest_in),
      .char_out(co_a), .char_valid(cv_a), .char_ready(char_ready),
      .busy(bz_a), .done(dn_a), .overrun(ov_a));

   digest_hex_serializer #(.DIGEST_W(64), .UPPERCASE(1), .EMIT_NEWLINE(0)) dut_b (
      .clk(clk), .rst(rst), .hash_ready(hash_ready), .digest_in(digest_in),
      .char_out(co_b), .char_valid(cv_b), .char_ready(char_ready),
      .busy(bz_b), .done(dn_b), .overrun(ov_b));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model, per instance: the text of the current stream and how
   // much of it has been taken.
   string mstr [2];
   int    mpos [2];
   bit    mdone[2];
   bit    movr [2];
   bit    mzero[2];
   bit    mhr  [2];

   byte unsigned cap_a[$];
   byte unsigned cap_b[$];

   typedef struct {
      logic [63:0] dig;
      string       exp_a;
      string       exp_b;
   } vec_t;

   function automatic string expect_str(input logic [63:0] d, input int c);
      string s;
      s = $sformatf("%016h", d);
      if (c == 1) s = s.toupper();
      else        s = {s, "\n"};
      return s;
   endfunction

   function automatic bit m_active(input int c);
      return mpos[c] < mstr[c].len();
   endfunction

   task automatic model_step(input bit r, input bit h, input logic [63:0] d, input bit rd);
      for (int c = 0; c < 2; c++) begin
         bit start;
         start = h && !mhr[c];
         if (r) begin
            mstr[c] = ""; mpos[c] = 0; mdone[c] = 0; movr[c] = 0; mzero[c] = 1; mhr[c] = 1;
         end else begin
            mdone[c] = 0;
            if (m_active(c)) begin
               if (start) movr[c] = 1;
               if (rd) begin
                  mpos[c]++;
                  if (mpos[c] == mstr[c].len()) mdone[c] = 1;
               end
            end else if (start) begin
               mstr[c] = expect_str(d, c); mpos[c] = 0; mzero[c] = 0;
            end
            mhr[c] = h;
         end
      end
   endtask

   task automatic check_dut(input int c, input logic [7:0] co, input logic cv,
                            input logic bz, input logic dn, input logic ov);
      logic [3:0]   exp_f, act_f;
      byte unsigned ec;
      exp_f = {m_active(c), m_active(c), mdone[c], movr[c]};
      act_f = {cv, bz, dn, ov};
      n_cmp++;
      if (act_f !== exp_f) begin
         n_bad++;
         $display("FAIL flags_%0d t=%0t valid/busy/done/overrun got %b want %b", c, $time, act_f, exp_f);
      end
      if (m_active(c)) begin
         ec = mstr[c][mpos[c]];
         n_cmp++;
         if (co !== ec) begin
            n_bad++;
            $display("FAIL char_%0d t=%0t got %02h want %02h", c, $time, co, ec);
         end
      end else if (mzero[c]) begin
         n_cmp++;
         if (co !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_char_%0d t=%0t got %02h want 00", c, $time, co);
         end
      end
   endtask

   // One clock: check outputs at the falling edge, record the transfer that the
   // coming rising edge will perform, then drive the new inputs.
   task automatic tick(input bit r, input bit h, input logic [63:0] d, input bit rd);
      @(negedge clk);
      check_dut(0, co_a, cv_a, bz_a, dn_a, ov_a);
      check_dut(1, co_b, cv_b, bz_b, dn_b, ov_b);
      if (cv_a && rd && !r) cap_a.push_back(co_a);
      if (cv_b && rd && !r) cap_b.push_back(co_b);
      rst = r; hash_ready = h; digest_in = d; char_ready = rd;
      model_step(r, h, d, rd);
   endtask

   task automatic clear_caps();
      cap_a.delete();
      cap_b.delete();
   endtask

   task automatic cmp_stream(input string name, input string exp, input int c);
      string act, ehex;
      bit    ok;
      int    n;
      act = ""; ehex = "";
      n  = (c == 0) ? cap_a.size() : cap_b.size();
      ok = (n == exp.len());
      for (int i = 0; i < n; i++) begin
         byte unsigned b;
         b = (c == 0) ? cap_a[i] : cap_b[i];
         act = {act, $sformatf("%02h", b)};
         if (ok && (b != exp[i])) ok = 0;
      end
      for (int i = 0; i < exp.len(); i++) ehex = {ehex, $sformatf("%02h", exp[i])};
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s got %s want %s", name, act, ehex);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %b want %b", name, act, exp);
      end
   endtask

   initial begin
      vec_t        tbl[4];
      logic [63:0] d, d2;
      int          k, stall;
      bit          rd, hr;

      tbl[0].dig = 64'h0123456789abcdef; tbl[0].exp_a = "0123456789abcdef\n"; tbl[0].exp_b = "0123456789ABCDEF";
      tbl[1].dig = 64'hfedcba9876543210; tbl[1].exp_a = "fedcba9876543210\n"; tbl[1].exp_b = "FEDCBA9876543210";
      tbl[2].dig = 64'h00000000ffffffff; tbl[2].exp_a = "00000000ffffffff\n"; tbl[2].exp_b = "00000000FFFFFFFF";
      tbl[3].dig = 64'hdeadbeefcafef00d; tbl[3].exp_a = "deadbeefcafef00d\n"; tbl[3].exp_b = "DEADBEEFCAFEF00D";

      rst = 1'b1; hash_ready = 1'b0; digest_in = 64'h0; char_ready = 1'b0;
      model_step(1'b1, 1'b0, 64'h0, 1'b0);
      tick(1'b1, 1'b0, 64'h0, 1'b0);
      tick(1'b0, 1'b0, 64'h0, 1'b1);   // reset state checked here

      // Table: full-throughput streams; digest_in scrambled after capture.
      for (int i = 0; i < 4; i++) begin
         clear_caps();
         tick(1'b0, 1'b0, tbl[i].dig, 1'b1);
         tick(1'b0, 1'b1, tbl[i].dig, 1'b1);
         for (int j = 1; j <= 20; j++) tick(1'b0, 1'b1, ~tbl[i].dig, 1'b1);
         cmp_stream($sformatf("table%0d_lower", i), tbl[i].exp_a, 0);
         cmp_stream($sformatf("table%0d_upper", i), tbl[i].exp_b, 1);
      end

      // Second edge mid-stream with a different digest: ignored, overrun sticks.
      d = 64'h1122334455667788; d2 = 64'h99aabbccddeeff00;
      tick(1'b1, 1'b0, d, 1'b1);
      clear_caps();
      tick(1'b0, 1'b0, d, 1'b1);
      tick(1'b0, 1'b1, d, 1'b1);
      for (int j = 1; j <= 20; j++) tick(1'b0, (j != 3), (j >= 4) ? d2 : d, 1'b1);
      cmp_stream("overrun_keep_lower", expect_str(d, 0), 0);
      cmp_stream("overrun_keep_upper", expect_str(d, 1), 1);
      for (int j = 0; j < 5; j++) tick(1'b0, 1'b0, d2, 1'b1);
      check_bit("overrun_sticky_a", ov_a, 1'b1);
      check_bit("overrun_sticky_b", ov_b, 1'b1);

      // Reset in the middle of a stream, then a clean restart.
      tick(1'b1, 1'b0, d, 1'b1);
      tick(1'b0, 1'b0, d, 1'b1);
      tick(1'b0, 1'b1, d, 1'b1);
      for (int j = 1; j <= 8; j++) tick(1'b0, 1'b1, d, 1'b1);
      tick(1'b1, 1'b1, d, 1'b1);
      for (int j = 0; j < 4; j++) tick(1'b0, 1'b0, d, 1'b1);
      check_bit("reset_mid_valid", cv_a, 1'b0);
      check_bit("reset_mid_overrun", ov_a, 1'b0);
      clear_caps();
      tick(1'b0, 1'b1, d2, 1'b1);
      for (int j = 1; j <= 20; j++) tick(1'b0, 1'b1, d, 1'b1);
      cmp_stream("restart_lower", expect_str(d2, 0), 0);
      cmp_stream("restart_upper", expect_str(d2, 1), 1);

      // hash_ready already high at reset release: no stream until re-raised.
      clear_caps();
      tick(1'b1, 1'b1, d, 1'b1);
      for (int j = 0; j < 40; j++) tick(1'b0, 1'b1, d, 1'b1);
      check_bit("held_high_no_out_a", (cap_a.size() == 0), 1'b1);
      check_bit("held_high_no_out_b", (cap_b.size() == 0), 1'b1);
      tick(1'b0, 1'b0, d, 1'b1);
      tick(1'b0, 1'b1, d, 1'b1);
      for (int j = 1; j <= 40; j++) tick(1'b0, 1'b1, d, 1'b1);
      cmp_stream("reraise_lower", expect_str(d, 0), 0);
      cmp_stream("reraise_upper", expect_str(d, 1), 1);

      // Edge coinciding with the final transfer of the lowercase instance.
      tick(1'b1, 1'b0, d, 1'b1);
      clear_caps();
      tick(1'b0, 1'b0, d, 1'b1);
      tick(1'b0, 1'b1, d, 1'b1);
      for (int j = 1; j <= 40; j++) tick(1'b0, (j != 16), (j >= 17) ? d2 : d, 1'b1);
      cmp_stream("final_edge_lower", expect_str(d, 0), 0);
      cmp_stream("final_edge_upper", {expect_str(d, 1), expect_str(d2, 1)}, 1);
      check_bit("final_edge_overrun_a", ov_a, 1'b1);
      check_bit("final_edge_overrun_b", ov_b, 1'b0);

      // Random digests with random sink stalls of 1-5 cycles.
      tick(1'b1, 1'b0, d, 1'b1);
      for (int s = 0; s < 6; s++) begin
         d = (s == 0) ? 64'h0123456789abcdef : {$urandom, $urandom};
         clear_caps();
         tick(1'b0, 1'b0, d, 1'b1);
         tick(1'b0, 1'b1, d, 1'b1);
         k = 0; stall = 0;
         while ((m_active(0) || m_active(1)) && (k < 300)) begin
            if (stall > 0) begin
               rd = 1'b0; stall--;
            end else begin
               rd = 1'b1;
               if ($urandom_range(0, 2) == 0) stall = $urandom_range(1, 5);
            end
            hr = (k != 2);
            tick(1'b0, hr, {$urandom, $urandom}, rd);
            k++;
         end
         n_cmp++;
         if (k >= 300) begin
            n_bad++;
            $display("FAIL random%0d_timeout got %0d cycles want under 300", s, k);
         end
         tick(1'b0, 1'b1, d, 1'b1);
         tick(1'b0, 1'b1, d, 1'b1);
         cmp_stream($sformatf("random%0d_lower", s), expect_str(d, 0), 0);
         cmp_stream($sformatf("random%0d_upper", s), expect_str(d, 1), 1);
      end

      tick(1'b0, 1'b0, 64'h0, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
